conv_icb_arb: RTL and testbench



---
 rtl/conv_icb_arb_if.sv | 25 ++
 rtl/conv_icb_arb.sv | 120 ++++++++++++
 tb/tb_conv_icb_arb.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_icb_arb_if.sv
// ICB bus bundle: command channel (valid/ready/read/addr/wdata/wmask) plus response channel.
// The master modport is the side that issues commands; the slave modport accepts them.
interface conv_icb_arb_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );
endinterface

// File: rtl/conv_icb_arb.sv
// 2:1 round-robin ICB arbiter (m0 = CPU, m1 = conv) onto one SRAM slave port, zero command latency,
// with an ID FIFO that steers the slave's in-order responses back to the issuing master.
module conv_icb_arb #(
    parameter int OUTS_DEPTH = 4,
    parameter int OUTS_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_icb_arb_if.slave        m0,
    conv_icb_arb_if.slave        m1,
    conv_icb_arb_if.master       s,
    output logic [OUTS_AW:0]     outs_cnt
);

    localparam logic [OUTS_AW:0] LP_DEPTH = (OUTS_AW+1)'(OUTS_DEPTH);

    logic               r_rr_last;
    logic               r_lock;
    logic               r_lock_id;
    logic [OUTS_AW-1:0] r_wptr;
    logic [OUTS_AW-1:0] r_rptr;
    logic [OUTS_AW:0]   r_cnt;
    logic               r_id_mem [OUTS_DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_gnt;
    logic               w_gnt_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_head_id;

    assign w_full  = (r_cnt == LP_DEPTH);
    assign w_empty = (r_cnt == '0);

    always_comb begin
        w_gnt = 1'b0;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else if (m0.icb_cmd_valid && !m1.icb_cmd_valid) begin
            w_gnt = 1'b0;
        end else if (!m0.icb_cmd_valid && m1.icb_cmd_valid) begin
            w_gnt = 1'b1;
        end else if (m0.icb_cmd_valid && m1.icb_cmd_valid) begin
            w_gnt = ~r_rr_last;
        end
    end

    // Command path: purely combinational mux, masked while the ID FIFO is full.
    assign w_gnt_valid     = w_gnt ? m1.icb_cmd_valid : m0.icb_cmd_valid;
    assign s.icb_cmd_valid = w_gnt_valid & ~w_full;
    assign s.icb_cmd_read  = w_gnt ? m1.icb_cmd_read  : m0.icb_cmd_read;
    assign s.icb_cmd_addr  = w_gnt ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
    assign s.icb_cmd_wdata = w_gnt ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
    assign s.icb_cmd_wmask = w_gnt ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;
    assign m0.icb_cmd_ready = ~w_gnt & s.icb_cmd_ready & ~w_full;
    assign m1.icb_cmd_ready =  w_gnt & s.icb_cmd_ready & ~w_full;

    assign w_push = s.icb_cmd_valid & s.icb_cmd_ready;

    // Response path: the head ID selects which master sees the slave response.
    assign w_head_id        = r_id_mem[r_rptr];
    assign m0.icb_rsp_valid = s.icb_rsp_valid & ~w_empty & ~w_head_id;
    assign m1.icb_rsp_valid = s.icb_rsp_valid & ~w_empty &  w_head_id;
    assign m0.icb_rsp_rdata = s.icb_rsp_rdata;
    assign m1.icb_rsp_rdata = s.icb_rsp_rdata;
    assign s.icb_rsp_ready  = ~w_empty & (w_head_id ? m1.icb_rsp_ready : m0.icb_rsp_ready);

    assign w_pop = s.icb_rsp_valid & s.icb_rsp_ready;

    assign outs_cnt = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (w_push) begin
            r_rr_last <= w_gnt;
            r_lock    <= 1'b0;
        end else if (s.icb_cmd_valid) begin
            // Presented but stalled: pin the grant so the command stays stable until accepted.
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < OUTS_DEPTH; gi++) begin : g_id_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_id_mem[gi] <= 1'b0;
                end else if (w_push && (r_wptr == OUTS_AW'(gi))) begin
                    r_id_mem[gi] <= w_gnt;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_conv_icb_arb.sv
// Directed bench for conv_icb_arb: round-robin grant, lock on stall, full blocking,
// in-order response routing with back-pressure, and asynchronous reset mid-traffic.
module tb_conv_icb_arb;

    logic       clk;
    logic       rst;
    logic [2:0] outs_cnt;

    int n_checks;
    int n_fail;

    conv_icb_arb_if m0_if ();
    conv_icb_arb_if m1_if ();
    conv_icb_arb_if s_if ();

    conv_icb_arb #(.OUTS_DEPTH(4), .OUTS_AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .s        (s_if.master),
        .outs_cnt (outs_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        m0_if.icb_cmd_valid = 1'b0; m0_if.icb_cmd_read = 1'b0; m0_if.icb_cmd_addr = '0;
        m0_if.icb_cmd_wdata = '0;   m0_if.icb_cmd_wmask = '0;  m0_if.icb_rsp_ready = 1'b0;
        m1_if.icb_cmd_valid = 1'b0; m1_if.icb_cmd_read = 1'b0; m1_if.icb_cmd_addr = '0;
        m1_if.icb_cmd_wdata = '0;   m1_if.icb_cmd_wmask = '0;  m1_if.icb_rsp_ready = 1'b0;
        s_if.icb_cmd_ready = 1'b0;  s_if.icb_rsp_valid = 1'b0; s_if.icb_rsp_rdata = '0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_outs_cnt", outs_cnt, 0);
        chk("rst_s_cmd_valid", s_if.icb_cmd_valid, 0);
        chk("rst_m0_cmd_ready", m0_if.icb_cmd_ready, 0);
        chk("rst_m1_cmd_ready", m1_if.icb_cmd_ready, 0);
        chk("rst_m0_rsp_valid", m0_if.icb_rsp_valid, 0);
        chk("rst_m1_rsp_valid", m1_if.icb_rsp_valid, 0);
        chk("rst_s_rsp_ready", s_if.icb_rsp_ready, 0);
        rst = 1'b0;
        s_if.icb_cmd_ready = 1'b1;
        m0_if.icb_rsp_ready = 1'b1;
        m1_if.icb_rsp_ready = 1'b1;
        #1;
        chk("idle_m0_ready_follows_gnt", m0_if.icb_cmd_ready, 1);
        chk("idle_m1_ready", m1_if.icb_cmd_ready, 0);

        // Single m1 read
        tick();
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_read = 1'b1; m1_if.icb_cmd_addr = 32'h4000_0000;
        #1;
        chk("t1_s_cmd_valid", s_if.icb_cmd_valid, 1);
        chk("t1_s_addr", s_if.icb_cmd_addr, 64'h4000_0000);
        chk("t1_s_read", s_if.icb_cmd_read, 1);
        chk("t1_m1_cmd_ready", m1_if.icb_cmd_ready, 1);
        chk("t1_m0_cmd_ready", m0_if.icb_cmd_ready, 0);
        chk("t1_cnt0", outs_cnt, 0);
        tick();
        m1_if.icb_cmd_valid = 1'b0;
        #1;
        chk("t1_cnt1", outs_cnt, 1);
        chk("t1_s_cmd_valid_low", s_if.icb_cmd_valid, 0);
        s_if.icb_rsp_valid = 1'b1; s_if.icb_rsp_rdata = 32'h1122_3344;
        #1;
        chk("t1_m1_rsp_valid", m1_if.icb_rsp_valid, 1);
        chk("t1_m1_rdata", m1_if.icb_rsp_rdata, 64'h1122_3344);
        chk("t1_m0_rsp_valid", m0_if.icb_rsp_valid, 0);
        chk("t1_s_rsp_ready", s_if.icb_rsp_ready, 1);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("t1_cnt_back0", outs_cnt, 0);

        // Both masters continuously valid: alternate m0,m1,m0,m1
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_read = 1'b1; m0_if.icb_cmd_addr = 32'h0000_0100;
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_read = 1'b1; m1_if.icb_cmd_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            s_if.icb_rsp_valid = (i > 0);
            s_if.icb_rsp_rdata = 32'hA0 + i;
            #1;
            chk($sformatf("rr%0d_m0_cmd_ready", i), m0_if.icb_cmd_ready, (i % 2 == 0));
            chk($sformatf("rr%0d_m1_cmd_ready", i), m1_if.icb_cmd_ready, (i % 2 == 1));
            chk($sformatf("rr%0d_s_addr", i), s_if.icb_cmd_addr, (i % 2 == 0) ? 64'h100 : 64'h200);
            if (i > 0) begin
                chk($sformatf("rr%0d_m0_rsp_valid", i), m0_if.icb_rsp_valid, ((i - 1) % 2 == 0));
                chk($sformatf("rr%0d_m1_rsp_valid", i), m1_if.icb_rsp_valid, ((i - 1) % 2 == 1));
                chk($sformatf("rr%0d_cnt", i), outs_cnt, 1);
            end else begin
                chk("rr0_cnt", outs_cnt, 0);
            end
            tick();
        end
        m0_if.icb_cmd_valid = 1'b0; m1_if.icb_cmd_valid = 1'b0;
        s_if.icb_rsp_valid = 1'b1;
        #1;
        chk("rr_last_m1_rsp_valid", m1_if.icb_rsp_valid, 1);
        chk("rr_last_m0_rsp_valid", m0_if.icb_rsp_valid, 0);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("rr_cnt_end", outs_cnt, 0);

        // Lock: m1 stalled by slave, m0 arrives later and must wait
        s_if.icb_cmd_ready = 1'b0;
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_read = 1'b0; m1_if.icb_cmd_addr = 32'h0000_0300;
        m1_if.icb_cmd_wdata = 32'hDEAD_BEEF; m1_if.icb_cmd_wmask = 4'hF;
        #1;
        chk("lk_s_cmd_valid", s_if.icb_cmd_valid, 1);
        chk("lk_s_addr0", s_if.icb_cmd_addr, 64'h300);
        chk("lk_s_wdata", s_if.icb_cmd_wdata, 64'hDEAD_BEEF);
        chk("lk_m1_cmd_ready0", m1_if.icb_cmd_ready, 0);
        tick();
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_read = 1'b1; m0_if.icb_cmd_addr = 32'h0000_0100;
        #1;
        chk("lk_s_addr1", s_if.icb_cmd_addr, 64'h300);
        chk("lk_m0_cmd_ready1", m0_if.icb_cmd_ready, 0);
        tick();
        #1;
        chk("lk_s_addr2", s_if.icb_cmd_addr, 64'h300);
        tick();
        s_if.icb_cmd_ready = 1'b1;
        #1;
        chk("lk_m1_accept", m1_if.icb_cmd_ready, 1);
        chk("lk_m0_wait", m0_if.icb_cmd_ready, 0);
        tick();
        m1_if.icb_cmd_valid = 1'b0;
        #1;
        chk("lk_m0_next", m0_if.icb_cmd_ready, 1);
        chk("lk_m0_addr", s_if.icb_cmd_addr, 64'h100);
        tick();
        m0_if.icb_cmd_valid = 1'b0;
        #1;
        chk("lk_cnt2", outs_cnt, 2);
        s_if.icb_rsp_valid = 1'b1;
        #1;
        chk("lk_rsp0_m1", m1_if.icb_rsp_valid, 1);
        chk("lk_rsp0_m0", m0_if.icb_rsp_valid, 0);
        tick();
        #1;
        chk("lk_rsp1_m0", m0_if.icb_rsp_valid, 1);
        chk("lk_rsp1_m1", m1_if.icb_rsp_valid, 0);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("lk_cnt0", outs_cnt, 0);

        // Full: m1 issues 5 writes with no responses
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m1_if.icb_cmd_addr = 32'h6000_0000 + 32'(4 * k);
            #1;
            chk($sformatf("fl%0d_m1_cmd_ready", k), m1_if.icb_cmd_ready, 1);
            chk($sformatf("fl%0d_s_addr", k), s_if.icb_cmd_addr, 64'h6000_0000 + 64'(4 * k));
            tick();
        end
        m1_if.icb_cmd_addr = 32'h6000_0010;
        #1;
        chk("fl_cnt4", outs_cnt, 4);
        chk("fl_m1_blocked", m1_if.icb_cmd_ready, 0);
        chk("fl_s_valid_masked", s_if.icb_cmd_valid, 0);
        tick();
        #1;
        chk("fl_m1_still_blocked", m1_if.icb_cmd_ready, 0);
        s_if.icb_rsp_valid = 1'b1;
        #1;
        chk("fl_s_rsp_ready", s_if.icb_rsp_ready, 1);
        chk("fl_push_blocked_on_pop", m1_if.icb_cmd_ready, 0);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("fl_cnt3", outs_cnt, 3);
        chk("fl_m1_5th_ready", m1_if.icb_cmd_ready, 1);
        chk("fl_5th_addr", s_if.icb_cmd_addr, 64'h6000_0010);
        tick();
        m1_if.icb_cmd_valid = 1'b0;
        #1;
        chk("fl_cnt4_again", outs_cnt, 4);
        s_if.icb_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fl_drain%0d_m1", k), m1_if.icb_rsp_valid, 1);
            tick();
        end
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("fl_cnt_drained", outs_cnt, 0);

        // Response back-pressure: m0 at head holds m1's response behind it
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_read = 1'b1; m0_if.icb_cmd_addr = 32'h0000_0500;
        #1;
        chk("bp_m0_issue", m0_if.icb_cmd_ready, 1);
        tick();
        m0_if.icb_cmd_valid = 1'b0;
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_read = 1'b1; m1_if.icb_cmd_addr = 32'h0000_0600;
        #1;
        chk("bp_m1_issue", m1_if.icb_cmd_ready, 1);
        tick();
        m1_if.icb_cmd_valid = 1'b0;
        m0_if.icb_rsp_ready = 1'b0;
        s_if.icb_rsp_valid = 1'b1; s_if.icb_rsp_rdata = 32'hBEEF_0000;
        #1;
        chk("bp_m0_rsp_valid", m0_if.icb_rsp_valid, 1);
        chk("bp_m1_rsp_valid", m1_if.icb_rsp_valid, 0);
        chk("bp_s_rsp_ready", s_if.icb_rsp_ready, 0);
        tick();
        #1;
        chk("bp_cnt_hold", outs_cnt, 2);
        chk("bp_s_rsp_ready_hold", s_if.icb_rsp_ready, 0);
        m0_if.icb_rsp_ready = 1'b1;
        #1;
        chk("bp_release", s_if.icb_rsp_ready, 1);
        chk("bp_m0_rdata", m0_if.icb_rsp_rdata, 64'hBEEF_0000);
        tick();
        s_if.icb_rsp_rdata = 32'hBEEF_0001;
        #1;
        chk("bp_m1_rsp_valid2", m1_if.icb_rsp_valid, 1);
        chk("bp_m0_rsp_valid2", m0_if.icb_rsp_valid, 0);
        chk("bp_m1_rdata", m1_if.icb_rsp_rdata, 64'hBEEF_0001);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        #1;
        chk("bp_cnt0", outs_cnt, 0);

        // Asynchronous reset with 3 outstanding
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_addr = 32'h0000_0700;
        tick(); tick(); tick();
        m0_if.icb_cmd_valid = 1'b0;
        #1;
        chk("ar_cnt3", outs_cnt, 3);
        s_if.icb_rsp_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("ar_cnt0", outs_cnt, 0);
        chk("ar_m0_rsp_valid", m0_if.icb_rsp_valid, 0);
        chk("ar_s_rsp_ready", s_if.icb_rsp_ready, 0);
        chk("ar_s_cmd_valid", s_if.icb_cmd_valid, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("ar_rsp_dropped", s_if.icb_rsp_ready, 0);
        tick();
        s_if.icb_rsp_valid = 1'b0;
        m0_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_valid = 1'b1;
        #1;
        chk("ar_first_contest_m0", m0_if.icb_cmd_ready, 1);
        chk("ar_first_contest_m1", m1_if.icb_cmd_ready, 0);
        chk("ar_addr_m0", s_if.icb_cmd_addr, 64'h700);
        tick();
        m0_if.icb_cmd_valid = 1'b0; m1_if.icb_cmd_valid = 1'b0;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
